// File: rtl/alu181_sliced.sv
// Bit-serial-by-slice 74181-compatible ALU: one SLICE-wide function generator reused
// across NSLICE clocks, with a registered ripple carry and a stored carry for chained ops.
module alu181_sliced #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cn_b,
  input  logic             chain,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cn4_b,
  output logic             aeb
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, f_q, f_d;
  logic [3:0]       s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             m_q, m_d, carry_q, carry_d, stored_q, stored_d;
  logic             busy_q, busy_d, done_q, done_d, cn4_b_q, cn4_b_d, aeb_q, aeb_d;

  logic [SLICE-1:0] a_sl, b_sl, e_v, d_v, sf;
  logic [SLICE:0]   cy;
  logic [WIDTH-1:0] res_nx;

  // One slice of the function generator; operands are consumed from the LSB end.
  always_comb begin
    a_sl  = a_q[SLICE-1:0];
    b_sl  = b_q[SLICE-1:0];
    e_v   = ~((a_sl & b_sl & {SLICE{s_q[3]}}) | (a_sl & ~b_sl & {SLICE{s_q[2]}}));
    d_v   = ~((~b_sl & {SLICE{s_q[1]}}) | (b_sl & {SLICE{s_q[0]}}) | a_sl);
    cy    = '0;
    cy[0] = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      cy[i+1] = ~d_v[i] & (cy[i] | ~e_v[i]);
    end
    sf     = e_v ^ d_v ^ (cy[SLICE-1:0] | {SLICE{m_q}});
    res_nx = (res_q >> SLICE) | (WIDTH'(sf) << (WIDTH - SLICE));
  end

  // Sequencing: latch on accept, one slice per RUN cycle, publish all outputs at the end.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    stored_d = stored_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    f_d      = f_q;
    cn4_b_d  = cn4_b_q;
    aeb_d    = aeb_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          carry_d = chain ? stored_q : ~cn_b;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        carry_d = cy[SLICE];
        res_d   = res_nx;
        if (cnt_q == CW'(NSLICE - 1)) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          f_d      = res_nx;
          cn4_b_d  = ~cy[SLICE];
          aeb_d    = &res_nx;
          stored_d = cy[SLICE];
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      stored_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      f_q      <= '0;
      cn4_b_q  <= 1'b1;
      aeb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      stored_q <= stored_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      f_q      <= f_d;
      cn4_b_q  <= cn4_b_d;
      aeb_q    <= aeb_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign f     = f_q;
  assign cn4_b = cn4_b_q;
  assign aeb   = aeb_q;

endmodule
